// File: rtl/router_pkg.sv
// Shared router definitions: flit geometry, route direction codes and the
// scheduler lock-state encoding used by every output port scheduler.
package router_pkg;

  localparam int FLIT_SIZE = 82;
  localparam int ROUTE_LEN = 3;
  localparam int PORT_NUM  = 6;

  localparam logic [ROUTE_LEN-1:0] DIR_INJECT = 3'd0;
  localparam logic [ROUTE_LEN-1:0] DIR_XPOS   = 3'd1;
  localparam logic [ROUTE_LEN-1:0] DIR_XNEG   = 3'd2;
  localparam logic [ROUTE_LEN-1:0] DIR_YPOS   = 3'd3;
  localparam logic [ROUTE_LEN-1:0] DIR_YNEG   = 3'd4;
  localparam logic [ROUTE_LEN-1:0] DIR_ZPOS   = 3'd5;
  localparam logic [ROUTE_LEN-1:0] DIR_ZNEG   = 3'd6;
  localparam logic [ROUTE_LEN-1:0] DIR_EJECT  = 3'd7;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

endpackage

// File: rtl/output_port_scheduler_if.sv
// Bundle of input-queue heads, pop strobes, output link and credit signals
// connecting one output port scheduler to its switch.
interface output_port_scheduler_if #(
  parameter int PORT_NUM  = router_pkg::PORT_NUM,
  parameter int FLIT_SIZE = router_pkg::FLIT_SIZE,
  parameter int ROUTE_LEN = router_pkg::ROUTE_LEN,
  parameter int CREDITS   = 5
);
  localparam int CNT_W = $clog2(CREDITS + 1);

  logic [PORT_NUM*FLIT_SIZE-1:0] in;
  logic [PORT_NUM*ROUTE_LEN-1:0] route_in;
  logic [PORT_NUM-1:0]           in_valid;
  logic [PORT_NUM-1:0]           in_pop;
  logic [FLIT_SIZE-1:0]          out;
  logic                          out_valid;
  logic                          credit_in;
  logic [CNT_W-1:0]              credit_cnt;
  logic                          credit_err;

  modport master (
    output in, route_in, in_valid, credit_in,
    input  in_pop, out, out_valid, credit_cnt, credit_err
  );

  modport slave (
    input  in, route_in, in_valid, credit_in,
    output in_pop, out, out_valid, credit_cnt, credit_err
  );

endinterface

// File: rtl/output_port_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found scanning
// upward from rr_ptr (wrapping) wins; grant is one-hot plus encoded index.
module rr_arbiter #(
  parameter int PORT_NUM = router_pkg::PORT_NUM,
  localparam int IDX_W   = $clog2(PORT_NUM)
) (
  input  logic [PORT_NUM-1:0] req,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic [PORT_NUM-1:0] gnt,
  output logic [IDX_W-1:0]    gnt_idx
);

  logic             found;
  logic [IDX_W:0]   cand;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 0; off < PORT_NUM; off++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(PORT_NUM)) cand = cand - (IDX_W+1)'(PORT_NUM);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                  = 1'b1;
        gnt[cand[IDX_W-1:0]]   = 1'b1;
        gnt_idx                = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/output_port_scheduler.sv
// Schedules one output direction among all input ports with round-robin
// priority and downstream credit flow control. Define PKT_LOCK_EN for wormhole packet locking.
module output_port_scheduler #(
  parameter int PORT_NUM  = router_pkg::PORT_NUM,
  parameter int FLIT_SIZE = router_pkg::FLIT_SIZE,
  parameter int ROUTE_LEN = router_pkg::ROUTE_LEN,
  parameter int MY_DIR    = int'(router_pkg::DIR_XPOS),
  parameter int CREDITS   = 5,
  parameter int TAIL_BIT  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output_port_scheduler_if.slave  bus
);
  import router_pkg::*;

  localparam int IDX_W = $clog2(PORT_NUM);
  localparam int CNT_W = $clog2(CREDITS + 1);

  logic [PORT_NUM-1:0]  req, req_m, gnt;
  logic [IDX_W-1:0]     gnt_idx, next_ptr;
  logic                 grant;
  logic [FLIT_SIZE-1:0] sel_flit;

  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     credit_cnt_q, credit_cnt_d;
  logic                 credit_err_q, credit_err_d;
  logic [FLIT_SIZE-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;

  always_comb begin
    req = '0;
    for (int i = 0; i < PORT_NUM; i++)
      req[i] = bus.in_valid[i] && (bus.route_in[i*ROUTE_LEN +: ROUTE_LEN] == ROUTE_LEN'(MY_DIR));
  end

`ifdef PKT_LOCK_EN
  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] lock_port_q, lock_port_d;
  logic             tail;

  // While a packet is in flight only its owner may keep requesting.
  assign req_m = (state_q == LOCKED) ? (req & (PORT_NUM'(1) << lock_port_q)) : req;
  assign tail  = sel_flit[TAIL_BIT];
`else
  assign req_m = req;
`endif

  rr_arbiter #(.PORT_NUM(PORT_NUM)) u_arb (
    .req     (req_m),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A credit returning this cycle is not usable until the counter has absorbed it.
  assign grant    = (|gnt) && (credit_cnt_q != '0) && !rst;
  assign sel_flit = bus.in[gnt_idx*FLIT_SIZE +: FLIT_SIZE];
  assign next_ptr = (gnt_idx == IDX_W'(PORT_NUM-1)) ? '0 : gnt_idx + IDX_W'(1);

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_d       = out_q;
    out_valid_d = grant;
    if (grant) out_d = sel_flit;
`ifdef PKT_LOCK_EN
    state_d     = state_q;
    lock_port_d = lock_port_q;
    if (grant && tail) rr_ptr_d = next_ptr;
    case (state_q)
      IDLE: begin
        if (grant && !tail) begin
          state_d     = LOCKED;
          lock_port_d = gnt_idx;
        end
      end
      LOCKED: begin
        if (grant && tail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`else
    if (grant) rr_ptr_d = next_ptr;
`endif
  end

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    if (bus.credit_in && (credit_cnt_q == CNT_W'(CREDITS))) credit_err_d = 1'b1;
    case ({grant, bus.credit_in})
      2'b10:   credit_cnt_d = credit_cnt_q - CNT_W'(1);
      2'b01:   if (credit_cnt_q != CNT_W'(CREDITS)) credit_cnt_d = credit_cnt_q + CNT_W'(1);
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      credit_cnt_q <= CNT_W'(CREDITS);
      credit_err_q <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
    end
  end

`ifdef PKT_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_port_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
    end
  end
`endif

  assign bus.in_pop     = grant ? gnt : '0;
  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.credit_cnt = credit_cnt_q;
  assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler: expected flits are queued when a
// grant is expected and a monitor pops and compares each out_valid pulse.
module tb_output_port_scheduler;
  import router_pkg::*;

  localparam int P  = 6;
  localparam int FW = 82;
  localparam int RL = 3;
  localparam int CR = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_port_scheduler_if #(.PORT_NUM(P), .FLIT_SIZE(FW), .ROUTE_LEN(RL), .CREDITS(CR)) bus ();

  output_port_scheduler #(
    .PORT_NUM(P), .FLIT_SIZE(FW), .ROUTE_LEN(RL),
    .MY_DIR(int'(DIR_XPOS)), .CREDITS(CR), .TAIL_BIT(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] exp_q[$];
  logic [P-1:0]  valid_v;
  int            rt[P];
  int            seq[P];
  int            plen[P];

  // Flit carries its port and sequence number; bit 0 is the tail flag.
  function automatic logic [FW-1:0] mk_flit(int p, int s, int len);
    logic [FW-1:0] f;
    logic [63:0]   pat;
    pat  = 64'hA5C3_0F00_0000_0000 ^ (64'(p) << 32) ^ 64'(s);
    f    = {8'(s), 8'(p), 1'b0, pat, 1'b0};
    f[0] = (len == 0) ? 1'b1 : ((s % len) == (len - 1));
    return f;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      bus.in[p*FW +: FW]       = mk_flit(p, seq[p], plen[p]);
      bus.route_in[p*RL +: RL] = RL'(rt[p]);
    end
    bus.in_valid = valid_v;
  endtask

  // One clock cycle: expect a grant to exp_port (or none when negative).
  task automatic step(int exp_port, bit crd);
    logic [P-1:0] e;
    bus.credit_in = crd;
    drive();
    @(negedge clk);
    e = '0;
    if (exp_port >= 0) begin
      e[exp_port] = 1'b1;
      exp_q.push_back(mk_flit(exp_port, seq[exp_port], plen[exp_port]));
    end
    check("in_pop", bus.in_pop, e);
    @(posedge clk);
    #1;
    if (exp_port >= 0) seq[exp_port]++;
    bus.credit_in = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    valid_v = '0;
    rst     = 1'b1;
    drive();
    #1;
    check("rst_in_pop", bus.in_pop, 0);
    check("rst_out", bus.out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_credit_cnt", bus.credit_cnt, CR);
    check("rst_credit_err", bus.credit_err, 0);
    exp_q.delete();
    for (int p = 0; p < P; p++) seq[p] = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got %0h expected no flit", bus.out);
      end else begin
        check("out_flit", bus.out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.credit_in = 1'b0;
    valid_v       = '0;
    for (int p = 0; p < P; p++) begin
      rt[p]   = 0;
      seq[p]  = 0;
      plen[p] = 0;
    end
    drive();
    do_reset();

    // Single requester; port 4 is valid but routed elsewhere.
    rt[2]   = int'(DIR_XPOS);
    rt[4]   = int'(DIR_YPOS);
    valid_v = 6'b010100;
    step(2, 1'b0);
    valid_v = '0;
    check("t1_cnt", bus.credit_cnt, 4);
    step(-1, 1'b0);
    check("t1_out_hold", bus.out, mk_flit(2, 0, 0));
    check("t1_idle_valid", bus.out_valid, 0);
    step(-1, 1'b1);
    check("t1_cnt_back", bus.credit_cnt, 5);

    // All ports requesting, credits returned every cycle after the first.
    do_reset();
    for (int p = 0; p < P; p++) rt[p] = int'(DIR_XPOS);
    valid_v = 6'b111111;
    step(0, 1'b0);
    for (int i = 1; i <= 6; i++) step(i % 6, 1'b1);
    valid_v = '0;
    check("t2_cnt", bus.credit_cnt, 4);
    check("t2_err", bus.credit_err, 0);
    step(-1, 1'b0);
    check("t2_drain", exp_q.size(), 0);

    // Credit exhaustion with a deep queue on port 3.
    do_reset();
    valid_v = 6'b001000;
    for (int i = 0; i < 5; i++) step(3, 1'b0);
    check("t3_cnt_empty", bus.credit_cnt, 0);
    step(-1, 1'b0);
    step(-1, 1'b0);
    check("t3_cnt_stays", bus.credit_cnt, 0);
    step(-1, 1'b1);
    check("t3_cnt_one", bus.credit_cnt, 1);
    step(3, 1'b0);
    check("t3_cnt_zero", bus.credit_cnt, 0);
    valid_v = '0;
    step(-1, 1'b0);
    check("t3_drain", exp_q.size(), 0);

    // Simultaneous grant and credit, then overflow of a full counter.
    for (int i = 0; i < 3; i++) step(-1, 1'b1);
    check("t4_cnt3", bus.credit_cnt, 3);
    valid_v = 6'b001000;
    step(3, 1'b1);
    valid_v = '0;
    check("t4_cnt_same", bus.credit_cnt, 3);
    step(-1, 1'b1);
    step(-1, 1'b1);
    check("t4_err_clear", bus.credit_err, 0);
    step(-1, 1'b1);
    check("t4_cnt_sat", bus.credit_cnt, 5);
    check("t4_err_set", bus.credit_err, 1);
    step(-1, 1'b0);
    check("t4_err_sticky", bus.credit_err, 1);
    check("t4_drain", exp_q.size(), 0);

    // Port 1 sends a 3-flit packet while port 0 competes.
    do_reset();
    plen[1] = 3;
    valid_v = 6'b000010;
    step(1, 1'b0);
    valid_v = 6'b000011;
`ifdef PKT_LOCK_EN
    step(1, 1'b0);
    step(1, 1'b0);
    step(0, 1'b0);
`else
    step(0, 1'b0);
    step(1, 1'b0);
    step(0, 1'b0);
`endif
    valid_v = '0;
    step(-1, 1'b0);
    check("t5_cnt", bus.credit_cnt, 1);
    check("t5_drain", exp_q.size(), 0);

    // Reset in the middle of a packet.
    do_reset();
    valid_v = 6'b000010;
    step(1, 1'b0);
    valid_v = 6'b000011;
    drive();
    rst = 1'b1;
    #1;
    check("t6_in_pop", bus.in_pop, 0);
    check("t6_out", bus.out, 0);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_cnt", bus.credit_cnt, 5);
    do_reset();
    valid_v = 6'b000011;
    step(0, 1'b0);
    valid_v = '0;
    step(-1, 1'b0);
    check("t6_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
